// File: rtl/rmt_checkpoint_ctrl.sv
// rmt_checkpoint_ctrl
//
// Branch checkpoint controller for the rename stage. Hands out checkpoint
// slots (a circular buffer of NUM_CKPT entries) to branches as they are
// renamed. It stores the post-branch mapping snapshot for each slot and frees
// slots in order as branches resolve correctly. On a mispredict it discards the
// wrong-path slots. It then drives a one-cycle recall of the saved snapshot
// back into the mapping table.
//
// Optional feature: define RMT_CKPT_STATS_EN to build the stall/recall
// statistics counters. Without it both stat outputs are tied to zero.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   ext_stall           rename stall, blocks allocation
//   ckpt_req/ckpt_slot  checkpoint request and the lane holding the branch
//   rmt_snapshot        mapping produced by the table for the new checkpoint
//   if_checkpoint       lane select to the mapping table (one-hot or zero)
//   ckpt_ack/ckpt_tag   allocation grant and the tag handed to the branch
//   ckpt_stall          rename must hold this cycle
//   resolve_*           branch resolution (tag, mispredict flag)
//   if_recall/flush_out recall strobe and wrong-path flush (registered)
//   recalled_rmt        snapshot being restored, zero outside a recall
//   stat_*_cnt          optional statistics counters
module rmt_checkpoint_ctrl #(
    parameter int NUM_CKPT = 4,
    parameter int TAG_W    = $clog2(NUM_CKPT),
    parameter int PREG_W   = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ext_stall,
    input  logic                   ckpt_req,
    input  logic                   ckpt_slot,
    input  logic [PREG_W*32-1:0]   rmt_snapshot,
    output logic [1:0]             if_checkpoint,
    output logic                   ckpt_ack,
    output logic [TAG_W-1:0]       ckpt_tag,
    output logic                   ckpt_stall,
    input  logic                   resolve_valid,
    input  logic [TAG_W-1:0]       resolve_tag,
    input  logic                   resolve_mispredict,
    output logic                   if_recall,
    output logic [PREG_W*32-1:0]   recalled_rmt,
    output logic                   flush_out,
    output logic [31:0]            stat_stall_cnt,
    output logic [31:0]            stat_recall_cnt
);

    typedef enum logic {IDLE, RECALL} state_t;

    localparam logic [TAG_W:0]   FULL_CNT = NUM_CKPT;
    localparam logic [TAG_W:0]   CNT_ONE  = 1;
    localparam logic [TAG_W-1:0] TAG_ONE  = 1;

    state_t                 state;
    logic [TAG_W-1:0]       head;
    logic [TAG_W-1:0]       tail;
    logic [TAG_W:0]         count;
    logic [NUM_CKPT-1:0]    valid;
    logic [NUM_CKPT-1:0]    resolved;
    logic [NUM_CKPT-1:0]    valid_next;
    logic [NUM_CKPT-1:0]    resolved_next;
    logic [PREG_W*32-1:0]   snap [NUM_CKPT];

    logic mispredict;
    logic correct;
    logic retire;

    assign mispredict = resolve_valid && resolve_mispredict && valid[resolve_tag];
    assign correct    = resolve_valid && !resolve_mispredict && valid[resolve_tag];

    // A mispredict on the head slot wipes the whole buffer, so the head must
    // not also retire that cycle or head and tail would disagree on empty.
    assign retire = valid[head] && resolved[head] && !(mispredict && resolve_tag == head);

    // Full check uses the registered count, so a same-cycle retire does not
    // free a slot for this cycle's request. Gated by reset so every output
    // reads zero while reset is held.
    always_comb begin
        ckpt_ack = reset && ckpt_req && (count < FULL_CNT) && !ext_stall &&
                   (state == IDLE) && !mispredict;
        if_checkpoint = 2'b00;
        if (ckpt_ack) begin
            if_checkpoint[ckpt_slot] = 1'b1;
        end
        ckpt_tag   = ckpt_ack ? tail : '0;
        ckpt_stall = reset && ((ckpt_req && !ckpt_ack) || (state == RECALL));
    end

    // Slots younger than or equal to the mispredicted one are found by their
    // distance from head, which also handles the full case (head == tail).
    always_comb begin
        valid_next    = valid;
        resolved_next = resolved;
        if (correct) begin
            resolved_next[resolve_tag] = 1'b1;
        end
        if (retire) begin
            valid_next[head] = 1'b0;
        end
        if (ckpt_ack) begin
            valid_next[tail]    = 1'b1;
            resolved_next[tail] = 1'b0;
        end
        if (mispredict) begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (valid[i] && ((TAG_W'(i) - head) >= (resolve_tag - head))) begin
                    valid_next[i] = 1'b0;
                end
            end
        end
    end

    // Snapshot storage needs no reset; a slot is only read once written.
    always_ff @(posedge clk) begin
        if (ckpt_ack) begin
            snap[tail] <= rmt_snapshot;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            valid        <= '0;
            resolved     <= '0;
            if_recall    <= 1'b0;
            flush_out    <= 1'b0;
            recalled_rmt <= '0;
        end else begin
            valid    <= valid_next;
            resolved <= resolved_next;
            if (retire) begin
                head <= head + TAG_ONE;
            end
            if (mispredict) begin
                // Also taken from RECALL: a new mispredict retargets the recall.
                state        <= RECALL;
                tail         <= resolve_tag;
                count        <= {1'b0, resolve_tag - head} - (retire ? CNT_ONE : '0);
                if_recall    <= 1'b1;
                flush_out    <= 1'b1;
                recalled_rmt <= snap[resolve_tag];
            end else begin
                state        <= IDLE;
                if_recall    <= 1'b0;
                flush_out    <= 1'b0;
                recalled_rmt <= '0;
                if (ckpt_ack) begin
                    tail <= tail + TAG_ONE;
                end
                case ({ckpt_ack, retire})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef RMT_CKPT_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_stall_cnt  <= '0;
            stat_recall_cnt <= '0;
        end else begin
            if (ckpt_req && (count == FULL_CNT) && !ext_stall) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (state == RECALL) begin
                stat_recall_cnt <= stat_recall_cnt + 32'd1;
            end
        end
    end
`else
    assign stat_stall_cnt  = '0;
    assign stat_recall_cnt = '0;
`endif

endmodule

// File: tb/tb_rmt_checkpoint_ctrl.sv
// Testbench for rmt_checkpoint_ctrl. A behavioural model keeps the live
// checkpoints as an ordered queue of tags. Expected ack tags and expected
// recall snapshots are queued when stimulus is driven and popped when the DUT
// raises ckpt_ack / if_recall.
module tb_rmt_checkpoint_ctrl;

    localparam int N = 4;
    localparam int W = 6 * 32;

    logic           clk;
    logic           reset;
    logic           ext_stall;
    logic           ckpt_req;
    logic           ckpt_slot;
    logic [W-1:0]   rmt_snapshot;
    logic [1:0]     if_checkpoint;
    logic           ckpt_ack;
    logic [1:0]     ckpt_tag;
    logic           ckpt_stall;
    logic           resolve_valid;
    logic [1:0]     resolve_tag;
    logic           resolve_mispredict;
    logic           if_recall;
    logic [W-1:0]   recalled_rmt;
    logic           flush_out;
    logic [31:0]    stat_stall_cnt;
    logic [31:0]    stat_recall_cnt;

    rmt_checkpoint_ctrl #(.NUM_CKPT(N), .TAG_W(2), .PREG_W(6)) dut (
        .clk                (clk),
        .reset              (reset),
        .ext_stall          (ext_stall),
        .ckpt_req           (ckpt_req),
        .ckpt_slot          (ckpt_slot),
        .rmt_snapshot       (rmt_snapshot),
        .if_checkpoint      (if_checkpoint),
        .ckpt_ack           (ckpt_ack),
        .ckpt_tag           (ckpt_tag),
        .ckpt_stall         (ckpt_stall),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_mispredict (resolve_mispredict),
        .if_recall          (if_recall),
        .recalled_rmt       (recalled_rmt),
        .flush_out          (flush_out),
        .stat_stall_cnt     (stat_stall_cnt),
        .stat_recall_cnt    (stat_recall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int           live[$];
    bit           m_res [N];
    logic [W-1:0] m_snap [N];
    int           m_tail = 0;
    bit           m_in_recall = 0;
    logic [31:0]  m_stall_cnt = 0;
    logic [31:0]  m_recall_cnt = 0;

    // Scoreboard queues
    int           tag_q[$];
    logic [W-1:0] recall_q[$];

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int find_live(input int t);
        for (int k = 0; k < live.size(); k++) begin
            if (live[k] == t) return k;
        end
        return -1;
    endfunction

    // Drives one cycle of stimulus (called just after a falling edge), checks
    // the DUT against the model mid-cycle, then advances the model to the
    // state it should hold after the next rising edge.
    task automatic applyStimulus(input bit rst, input bit req, input bit slot, input bit ext,
                                 input bit rv, input int rtag, input bit rmis);
        bit           m_mis;
        bit           m_corr;
        bit           exp_ack;
        bit           exp_stall;
        bit           retire_now;
        logic [1:0]   exp_ifc;
        int           idx;
        reset              = !rst;
        ckpt_req           = req;
        ckpt_slot          = slot;
        ext_stall          = ext;
        resolve_valid      = rv;
        resolve_tag        = 2'(rtag);
        resolve_mispredict = rmis;
        rmt_snapshot       = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        #1;
        idx       = find_live(rtag);
        m_mis     = !rst && rv && rmis && (idx >= 0);
        m_corr    = !rst && rv && !rmis && (idx >= 0);
        exp_ack   = !rst && req && (live.size() < N) && !ext && !m_in_recall && !m_mis;
        exp_ifc   = exp_ack ? (slot ? 2'b10 : 2'b01) : 2'b00;
        exp_stall = !rst && ((req && !exp_ack) || m_in_recall);

        checkOutput("ckpt_ack", W'(ckpt_ack), W'(exp_ack));
        checkOutput("if_checkpoint", W'(if_checkpoint), W'(exp_ifc));
        checkOutput("ckpt_stall", W'(ckpt_stall), W'(exp_stall));
        checkOutput("if_recall", W'(if_recall), W'(m_in_recall));
        checkOutput("flush_out", W'(flush_out), W'(m_in_recall));

        if (exp_ack) tag_q.push_back(m_tail);
        if (ckpt_ack) begin
            if (tag_q.size() > 0) checkOutput("ckpt_tag", W'(ckpt_tag), W'(tag_q.pop_front()));
            else                  checkOutput("unexpected_ack", W'(1), W'(0));
        end
        if (if_recall) begin
            if (recall_q.size() > 0) checkOutput("recalled_rmt", recalled_rmt, recall_q.pop_front());
            else                     checkOutput("unexpected_recall", W'(1), W'(0));
        end else begin
            checkOutput("recalled_rmt_idle", recalled_rmt, '0);
        end

`ifdef RMT_CKPT_STATS_EN
        checkOutput("stat_stall_cnt", W'(stat_stall_cnt), W'(m_stall_cnt));
        checkOutput("stat_recall_cnt", W'(stat_recall_cnt), W'(m_recall_cnt));
`else
        checkOutput("stat_stall_cnt", W'(stat_stall_cnt), '0);
        checkOutput("stat_recall_cnt", W'(stat_recall_cnt), '0);
`endif

        if (rst) begin
            live.delete();
            m_tail       = 0;
            m_in_recall  = 0;
            m_stall_cnt  = 0;
            m_recall_cnt = 0;
            for (int k = 0; k < N; k++) m_res[k] = 0;
        end else begin
            retire_now = (live.size() > 0) && m_res[live[0]] && !(m_mis && rtag == live[0]);
            if (req && live.size() == N && !ext) m_stall_cnt++;
            if (m_in_recall) m_recall_cnt++;
            if (m_mis) begin
                recall_q.push_back(m_snap[rtag]);
                while (live.size() > idx) void'(live.pop_back());
                m_tail      = rtag;
                m_in_recall = 1;
            end else begin
                m_in_recall = 0;
            end
            if (retire_now) void'(live.pop_front());
            if (m_corr) m_res[rtag] = 1;
            if (exp_ack) begin
                live.push_back(m_tail);
                m_res[m_tail]  = 0;
                m_snap[m_tail] = rmt_snapshot;
                m_tail         = (m_tail + 1) % N;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; ext_stall = 1'b0; ckpt_req = 1'b0; ckpt_slot = 1'b0;
        resolve_valid = 1'b0; resolve_tag = 2'd0; resolve_mispredict = 1'b0;
        rmt_snapshot = '0;
        @(negedge clk);

        // Reset with a request held: everything stays quiet
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        // Fill: tags 0..3, then a stalled fifth request
        repeat (5) applyStimulus(0, 1, 0, 0, 0, 0, 0);
        // Resolve tag 0 while full; retire next cycle; ack tag 0 after that
        applyStimulus(0, 1, 0, 0, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);

        // Out-of-order resolves 3,2 hold until 1 resolves, then retire in order
        applyStimulus(0, 0, 0, 0, 1, 3, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 2, 0);
        applyStimulus(0, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0);
        repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (4) applyStimulus(0, 1, 1, 0, 0, 0, 0);

        // Mispredict tag 1 with tags 0..3 live, recall, then reallocate tag 1..3
        applyStimulus(0, 0, 0, 0, 1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (3) applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Mispredict tag 2 while requesting
        applyStimulus(0, 1, 0, 0, 1, 2, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Mispredict to an unallocated tag is ignored
        applyStimulus(0, 0, 0, 0, 1, 3, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // Retarget: second mispredict during the recall cycle
        applyStimulus(0, 0, 0, 0, 1, 2, 1);
        applyStimulus(0, 1, 0, 0, 1, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);

        // External stall blocks allocation
        applyStimulus(0, 1, 0, 1, 0, 0, 0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0),
                          int'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0));
        end

        // Reset asserted during the recall cycle
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);

        checkOutput("tag_q_drained", W'(tag_q.size()), '0);
        checkOutput("recall_q_drained", W'(recall_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
